// File: rtl/disp_arb_pkg.sv
// Shared types for the display arbiter.
//   disp_word_t : four hex digits {d3,d2,d1,d0}, d3 is the leftmost digit
//   arb_state_t : IDLE (background shown) / SHOW (overlay latched)
//   id_w()      : source-id width for a given source count (at least 1 bit)
package disp_arb_pkg;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } disp_word_t;

  typedef enum logic {IDLE, SHOW} arb_state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_REQ_DEF = 3;
  typedef logic [id_w(N_REQ_DEF)-1:0] src_id_t;

endpackage

// File: rtl/disp_hold_timer.sv
// Restartable modulo-LIMIT counter with terminal-count flag.
// Ports:
//   clk   in  clock
//   clear in  async active-high reset (count -> 0)
//   load  in  restart count at 0 (wins over en)
//   en    in  advance count this edge; wraps to 0 after LIMIT-1
//   tc    out high while count == LIMIT-1
module disp_hold_timer #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear)     r_cnt <= '0;
    else if (load) r_cnt <= '0;
    else if (en)   r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  assign tc = (r_cnt == LAST);

endmodule

// File: rtl/display_arbiter.sv
// Shares the 4-digit 7-seg display between the background source (index 0)
// and N_REQ-1 overlay requesters. Highest requesting index wins; an overlay
// holds for HOLD_CYCLES cycles unless a higher index preempts it.
// Ports:
//   clk, clear            clock, async active-high reset
//   req[N_REQ]            overlay requests (bit 0 ignored)
//   value[N_REQ][16]      per-source digits {d3,d2,d1,d0}
//   ena[N_REQ][4]         per-source digit enables
//   grant[N_REQ]          one-cycle pulse when a source is latched
//   busy                  overlay on display
//   active_id             source on display (0 = background)
//   digit3..digit0        digits to display_controller
//   enables               digit enables to display_controller
// Config macro DISP_BLINK_EN: overlay enables blink with half-period
// BLINK_DIV cycles, phase restarted "on" at every grant.
module display_arbiter
  import disp_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0][15:0]      value,
  input  logic [N_REQ-1:0][3:0]       ena,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic [id_w(N_REQ)-1:0]      active_id,
  output logic [3:0]                  digit3,
  output logic [3:0]                  digit2,
  output logic [3:0]                  digit1,
  output logic [3:0]                  digit0,
  output logic [3:0]                  enables
);

  localparam int IDW = id_w(N_REQ);

  if (N_REQ < 2 || HOLD_CYCLES < 2 || BLINK_DIV < 1) begin : g_bad_param
    $error("display_arbiter: parameter out of range");
  end

  arb_state_t       r_state, w_nxt_state;
  disp_word_t       r_word;
  logic [3:0]       r_ena;
  logic [IDW-1:0]   r_id;
  logic [N_REQ-1:0] r_grant;

  logic [N_REQ-1:0] w_req, w_oh;
  logic [IDW-1:0]   w_hi;
  logic             w_any, w_do_grant, w_to_idle, w_hold_tc;
  logic [15:0]      w_sel_word;
  logic [3:0]       w_sel_ena;

  // A source whose grant is still visible has already been served; masking
  // it prevents a double grant while the requester drops its line.
  assign w_req = req & ~r_grant & ~N_REQ'(1);

  always_comb begin
    w_hi       = '0;
    w_any      = 1'b0;
    w_oh       = '0;
    w_sel_word = value[0];
    w_sel_ena  = ena[0];
    for (int i = 1; i < N_REQ; i++) begin
      if (w_req[i]) begin
        w_hi       = IDW'(i);
        w_any      = 1'b1;
        w_oh       = '0;
        w_oh[i]    = 1'b1;
        w_sel_word = value[i];
        w_sel_ena  = ena[i];
      end
    end
  end

  // Grant on any request in IDLE, on a higher index in SHOW, or on any
  // pending request at expiry (no background cycle in between).
  always_comb begin
    w_nxt_state = r_state;
    w_do_grant  = 1'b0;
    w_to_idle   = 1'b0;
    case (r_state)
      IDLE: w_do_grant = w_any;
      SHOW: begin
        w_do_grant = w_any && ((w_hi > r_id) || w_hold_tc);
        w_to_idle  = w_hold_tc && !w_any;
      end
      default: ;
    endcase
    if (w_do_grant)     w_nxt_state = SHOW;
    else if (w_to_idle) w_nxt_state = IDLE;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_nxt_state;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_grant <= '0;
      r_word  <= '0;
      r_ena   <= '0;
      r_id    <= '0;
    end else begin
      r_grant <= w_do_grant ? w_oh : '0;
      if (w_do_grant) begin
        r_word <= w_sel_word;
        r_ena  <= w_sel_ena;
        r_id   <= w_hi;
      end else if (r_state == IDLE || w_to_idle) begin
        r_word <= value[0];
        r_ena  <= ena[0];
        r_id   <= '0;
      end
    end
  end

  // Restarted at every grant, so the sampled count is cycles since grant.
  disp_hold_timer #(.LIMIT(HOLD_CYCLES)) u_hold (
    .clk   (clk),
    .clear (clear),
    .load  (w_do_grant),
    .en    (r_state == SHOW),
    .tc    (w_hold_tc)
  );

`ifdef DISP_BLINK_EN
  logic w_blink_tc;
  logic r_phase;

  disp_hold_timer #(.LIMIT(BLINK_DIV)) u_blink (
    .clk   (clk),
    .clear (clear),
    .load  (w_do_grant),
    .en    (r_state == SHOW),
    .tc    (w_blink_tc)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear)                              r_phase <= 1'b1;
    else if (w_do_grant)                    r_phase <= 1'b1;
    else if (r_state == SHOW && w_blink_tc) r_phase <= ~r_phase;
  end

  assign enables = (r_state == SHOW && !r_phase) ? 4'h0 : r_ena;
`else
  assign enables = r_ena;
`endif

  assign grant     = r_grant;
  assign busy      = (r_state == SHOW);
  assign active_id = r_id;
  assign digit3    = r_word.d3;
  assign digit2    = r_word.d2;
  assign digit1    = r_word.d1;
  assign digit0    = r_word.d0;

endmodule

// File: tb/tb_display_arbiter.sv
module tb_display_arbiter;

  logic            clk = 1'b0;
  logic            clear;
  logic [2:0]      req;
  logic [2:0][15:0] value;
  logic [2:0][3:0] ena;
  logic [2:0]      grant;
  logic            busy;
  logic [1:0]      active_id;
  logic [3:0]      digit3, digit2, digit1, digit0, enables;

  int total = 0;
  int bad   = 0;
  int n;
  logic gbad;
  logic [3:0] en_seq [0:31];
  logic [15:0] dig;

  assign dig = {digit3, digit2, digit1, digit0};

  display_arbiter #(.N_REQ(3), .HOLD_CYCLES(8), .BLINK_DIV(2)) dut (
    .clk(clk), .clear(clear), .req(req), .value(value), .ena(ena),
    .grant(grant), .busy(busy), .active_id(active_id),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .enables(enables)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample 1 ns after the edge; requesters drop req once they see grant.
  task automatic tick();
    @(posedge clk);
    #1;
    req = req & ~grant;
  endtask

  // Count consecutive samples (starting with the current one) showing w.
  task automatic hold_len(input logic [15:0] w, output int cnt);
    cnt  = 0;
    gbad = 1'b0;
    while (cnt < 30 && dig == w) begin
      en_seq[cnt] = enables;
      if (cnt > 0 && grant != 3'b000) gbad = 1'b1;
      cnt++;
      tick();
    end
  endtask

  initial begin
    clear = 1'b1;
    req   = '0;
    value = '0;
    ena   = '0;
    #12;
    // 1: reset state, then background with one-cycle latency
    chk("rst_dig",   {16'h0, dig}, 32'h0);
    chk("rst_en",    {28'h0, enables}, 32'h0);
    chk("rst_grant", {29'h0, grant}, 32'h0);
    chk("rst_busy",  {31'h0, busy}, 32'h0);
    value[0] = 16'h1234;
    ena[0]   = 4'hF;
    value[1] = 16'hBEEF;
    ena[1]   = 4'hA;
    value[2] = 16'h00FF;
    ena[2]   = 4'hF;
    #1 clear = 1'b0;
    tick();
    chk("bg_dig", {16'h0, dig}, 32'h1234);
    chk("bg_en",  {28'h0, enables}, 32'hF);

    // 2: single overlay, exact hold length, return to background
    req[1] = 1'b1;
    tick();
    chk("ov1_grant", {29'h0, grant}, 32'h2);
    chk("ov1_busy",  {31'h0, busy}, 32'h1);
    chk("ov1_id",    {30'h0, active_id}, 32'h1);
    chk("ov1_en",    {28'h0, enables}, 32'hA);
    hold_len(16'hBEEF, n);
    chk("ov1_len",    n, 8);
    chk("ov1_gpulse", {31'h0, gbad}, 32'h0);
`ifdef DISP_BLINK_EN
    chk("ov1_blink", {en_seq[0], en_seq[1], en_seq[2], en_seq[3],
                      en_seq[4], en_seq[5], en_seq[6], en_seq[7]}, 32'hAA00AA00);
`else
    chk("ov1_steady", {en_seq[0], en_seq[1], en_seq[2], en_seq[3],
                       en_seq[4], en_seq[5], en_seq[6], en_seq[7]}, 32'hAAAAAAAA);
`endif
    chk("ov1_back_dig",  {16'h0, dig}, 32'h1234);
    chk("ov1_back_busy", {31'h0, busy}, 32'h0);
    chk("ov1_back_id",   {30'h0, active_id}, 32'h0);

    // 3: preempt overlay 1 at timer=3 with overlay 2
    req[1] = 1'b1;
    tick();
    chk("p_g1", {29'h0, grant}, 32'h2);
    repeat (3) tick();
    chk("p_mid_dig", {16'h0, dig}, 32'hBEEF);
    req[2] = 1'b1;
    tick();
    chk("p_grant", {29'h0, grant}, 32'h4);
    chk("p_id",    {30'h0, active_id}, 32'h2);
    chk("p_dig",   {16'h0, dig}, 32'h00FF);
    // 4: lower request waits, then is granted on the expiry edge
    req[1] = 1'b1;
    hold_len(16'h00FF, n);
    chk("p_len",       n, 8);
    chk("wait_nogrant", {31'h0, gbad}, 32'h0);
    chk("exp_grant",   {29'h0, grant}, 32'h2);
    chk("exp_dig",     {16'h0, dig}, 32'hBEEF);
    chk("exp_id",      {30'h0, active_id}, 32'h1);
    hold_len(16'hBEEF, n);
    chk("exp_len",  n, 8);
    chk("exp_back", {16'h0, dig}, 32'h1234);

    // 5: simultaneous requests in IDLE
    req = 3'b110;
    tick();
    chk("sim_grant", {29'h0, grant}, 32'h4);
    chk("sim_id",    {30'h0, active_id}, 32'h2);
    hold_len(16'h00FF, n);
    chk("sim_len",    n, 8);
    chk("sim_grant1", {29'h0, grant}, 32'h2);
    chk("sim_dig1",   {16'h0, dig}, 32'hBEEF);
    hold_len(16'hBEEF, n);
    chk("sim_back", {16'h0, dig}, 32'h1234);

    // 6: clear mid-overlay, held request re-arbitrated after release
    req[2] = 1'b1;
    tick();
    chk("clr_g2", {29'h0, grant}, 32'h4);
    req[1] = 1'b1;
    tick();
    tick();
    #2 clear = 1'b1;
    #1;
    chk("clr_dig",   {16'h0, dig}, 32'h0);
    chk("clr_en",    {28'h0, enables}, 32'h0);
    chk("clr_busy",  {31'h0, busy}, 32'h0);
    chk("clr_grant", {29'h0, grant}, 32'h0);
    chk("clr_id",    {30'h0, active_id}, 32'h0);
    #3 clear = 1'b0;
    tick();
    chk("rel_grant", {29'h0, grant}, 32'h2);
    chk("rel_dig",   {16'h0, dig}, 32'hBEEF);
    chk("rel_id",    {30'h0, active_id}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
